// File: rtl/alu_seq.sv
// alu_seq: handshaked WISC ALU with a registered Z/V/N flag file and a
// one-bit-per-cycle shifter for SLL/SRA/ROR.
//
// state | meaning
// IDLE  | accepting ops; non-shift ops and zero-amount shifts complete here
// SHIFT | work register moves one bit per cycle until the count is spent
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4,
    parameter int SHW   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [7:0]       imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [2:0]       flags_o,
    output logic             busy_o
);
    localparam int NLANE = WIDTH / LANE;
    localparam int NBYTE = WIDTH / 8;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       flags_q;
    logic             out_valid_q;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       kind_q;

    logic             accept;
    logic             is_shift;
    logic             ovf;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] alu_d;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] padd;
    logic [WIDTH-1:0] red;
    logic             add_ovf;
    logic             sub_ovf;
    logic [LANE-1:0]  la;
    logic [LANE-1:0]  lb;
    logic [LANE-1:0]  ls;

    assign in_ready_o  = (state_q == IDLE) && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign is_shift    = (opcode_i == 4'h4) || (opcode_i == 4'h5) || (opcode_i == 4'h6);
    assign amt         = imm_i[SHW-1:0];
    assign ovf         = opcode_i[0] ? sub_ovf : add_ovf;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign busy_o      = (state_q == SHIFT);

    always_comb begin
        sum     = a_i + b_i;
        diff    = a_i - b_i;
        add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

        padd = '0;
        la   = '0;
        lb   = '0;
        ls   = '0;
        for (int i = 0; i < NLANE; i++) begin
            la = a_i[i*LANE +: LANE];
            lb = b_i[i*LANE +: LANE];
            ls = la + lb;
            if ((la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]))
                ls = la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
            padd[i*LANE +: LANE] = ls;
        end

        red = '0;
        for (int i = 0; i < NBYTE; i++)
            red = red + {{(WIDTH-8){a_i[i*8+7]}}, a_i[i*8 +: 8]}
                      + {{(WIDTH-8){b_i[i*8+7]}}, b_i[i*8 +: 8]};

        alu_d = '0;
        case (opcode_i)
            4'h0:               alu_d = add_ovf ? (a_i[WIDTH-1] ? SAT_NEG : SAT_POS) : sum;
            4'h1:               alu_d = sub_ovf ? (a_i[WIDTH-1] ? SAT_NEG : SAT_POS) : diff;
            4'h2:               alu_d = a_i ^ b_i;
            4'h3:               alu_d = red;
            4'h4, 4'h5, 4'h6:   alu_d = a_i;
            4'h7:               alu_d = padd;
            4'h8, 4'h9:         alu_d = {a_i[WIDTH-1:1], 1'b0}
                                      + {{(WIDTH-5){imm_i[3]}}, imm_i[3:0], 1'b0};
            4'hA:               alu_d = {a_i[WIDTH-1:8], imm_i};
            4'hB: begin
                alu_d       = a_i;
                alu_d[15:8] = imm_i;
            end
            default:            alu_d = '0;
        endcase
    end

    // kind_q holds opcode[1:0]: 0 = SLL, 1 = SRA, 2 = ROR
    always_comb begin
        case (kind_q)
            2'd0:    shift_d = {work_q[WIDTH-2:0], 1'b0};
            2'd1:    shift_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shift_d = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            result_q    <= '0;
            work_q      <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            kind_q      <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready_i)
                out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_shift && (amt != '0)) begin
                            work_q  <= a_i;
                            cnt_q   <= amt;
                            kind_q  <= opcode_i[1:0];
                            state_q <= SHIFT;
                        end else begin
                            result_q    <= alu_d;
                            out_valid_q <= 1'b1;
                            case (opcode_i)
                                4'h0, 4'h1:             flags_q    <= {alu_d == '0, ovf, alu_d[WIDTH-1]};
                                4'h2, 4'h4, 4'h5, 4'h6: flags_q[2] <= (alu_d == '0);
                                default: ;
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q    <= shift_d;
                        out_valid_q <= 1'b1;
                        flags_q[2]  <= (shift_d == '0);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized ops checked
// against an integer-arithmetic reference model of the WISC opcode rules.
module tb_alu_seq;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  flags;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [2:0]  mflags = '0;

    alu_seq #(.WIDTH(16), .LANE(4), .SHW(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .opcode_i   (opcode),
        .a_i        (a),
        .b_i        (b),
        .imm_i      (imm),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .flags_o    (flags),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns {flags, result}; flags passed in are the current flag file.
    function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] x,
                                          input logic [15:0] y, input logic [7:0] im,
                                          input logic [2:0] fl);
        logic [15:0]        r;
        logic [2:0]         f;
        int                 s;
        int                 amt;
        logic signed [15:0] sx;
        logic signed [7:0]  sb;
        logic signed [3:0]  lx;
        logic signed [3:0]  ly;
        r   = '0;
        f   = fl;
        s   = 0;
        amt = int'(im[3:0]);
        case (op)
            4'h0, 4'h1: begin
                sx = x;
                s  = int'(sx);
                sx = y;
                s  = (op == 4'h0) ? s + int'(sx) : s - int'(sx);
                f[1] = (s > 32767) || (s < -32768);
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
                r    = s[15:0];
                f[2] = (r == 16'h0000);
                f[0] = r[15];
            end
            4'h2: begin
                r    = x ^ y;
                f[2] = (r == 16'h0000);
            end
            4'h3: begin
                for (int k = 0; k < 2; k++) begin
                    sb = x[8*k +: 8];
                    s  = s + int'(sb);
                    sb = y[8*k +: 8];
                    s  = s + int'(sb);
                end
                r = s[15:0];
            end
            4'h4, 4'h5, 4'h6: begin
                if (op == 4'h4) r = x << amt;
                else if (op == 4'h5) begin
                    sx = x;
                    sx = sx >>> amt;
                    r  = sx;
                end else r = (amt == 0) ? x : ((x >> amt) | (x << (16 - amt)));
                f[2] = (r == 16'h0000);
            end
            4'h7: begin
                for (int l = 0; l < 4; l++) begin
                    lx = x[4*l +: 4];
                    ly = y[4*l +: 4];
                    s  = int'(lx) + int'(ly);
                    if (s > 7)  s = 7;
                    if (s < -8) s = -8;
                    r[4*l +: 4] = s[3:0];
                end
            end
            4'h8, 4'h9: begin
                s = int'(x & 16'hFFFE) + 2 * (im[3] ? amt - 16 : amt);
                r = s[15:0];
            end
            4'hA: r = {x[15:8], im};
            4'hB: r = {im, x[7:0]};
            default: r = '0;
        endcase
        return {f, r};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 6))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] im);
        opcode = op;
        a      = x;
        b      = y;
        imm    = im;
    endtask

    // Presents an op and returns just after the edge that accepted it.
    task automatic send_op(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] im, output bit ok);
        int k;
        set_op(op, x, y, im);
        in_valid = 1'b1;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles after the accept edge until out_valid; -1 when the bound expires.
    task automatic wait_valid(output int n, output bit rdy_seen, output bit busy_seen);
        n         = 0;
        rdy_seen  = 1'b0;
        busy_seen = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            if (busy)     busy_seen = 1'b1;
            tick();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(4'h0, 16'h0, 16'h0, 8'h0);
        repeat (2) tick();
        checks++;
        if (result !== 16'h0 || flags !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h flags=%b out_valid=%b busy=%b, want 0000 000 0 0",
                     result, flags, out_valid, busy);
        end
        rst_n = 1'b1;
        mflags = 3'b000;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add_sub();
        logic [18:0] ev;
        bit ok, r1, b1;
        int n;
        ev = model(4'h0, 16'h7FF0, 16'h0020, 8'h00, mflags);
        send_op(4'h0, 16'h7FF0, 16'h0020, 8'h00, ok);
        wait_valid(n, r1, b1);
        checks++;
        if (!ok || n != 0 || result !== 16'h7FFF || flags !== 3'b010 || ev !== {3'b010, 16'h7FFF}) begin
            errors++;
            $display("FAIL add_sat: ok=%b lat=%0d result=%h flags=%b, want lat=0 result=7fff flags=010",
                     ok, n, result, flags);
        end
        mflags = ev[18:16];
        send_op(4'h1, 16'h0005, 16'h0005, 8'h00, ok);
        wait_valid(n, r1, b1);
        checks++;
        if (!ok || n != 0 || result !== 16'h0000 || flags !== 3'b100) begin
            errors++;
            $display("FAIL sub_zero: ok=%b lat=%0d result=%h flags=%b, want lat=0 result=0000 flags=100",
                     ok, n, result, flags);
        end
        mflags = 3'b100;
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [15:0] x, y;
            op = 4'(i % 2);
            x  = rnd16();
            y  = rnd16();
            ev = model(op, x, y, 8'h00, mflags);
            send_op(op, x, y, 8'h00, ok);
            wait_valid(n, r1, b1);
            checks++;
            if (!ok || n != 0 || result !== ev[15:0] || flags !== ev[18:16]) begin
                errors++;
                $display("FAIL add_sub_rand op=%h a=%h b=%h: lat=%0d result=%h flags=%b, want lat=0 result=%h flags=%b",
                         op, x, y, n, result, flags, ev[15:0], ev[18:16]);
            end
            mflags = ev[18:16];
        end
    endtask

    task automatic test_shift();
        logic [18:0] ev;
        bit ok, rdy, bsy;
        int n;
        ev = model(4'h4, 16'h0001, 16'h0000, 8'h0F, mflags);
        send_op(4'h4, 16'h0001, 16'h0000, 8'h0F, ok);
        wait_valid(n, rdy, bsy);
        checks++;
        if (!ok || n != 15 || rdy || !bsy || result !== 16'h8000 || flags !== ev[18:16] || flags[2] !== 1'b0) begin
            errors++;
            $display("FAIL sll15: lat=%0d in_ready_seen=%b busy_seen=%b result=%h flags=%b, want lat=15 0 1 8000 %b",
                     n, rdy, bsy, result, flags, ev[18:16]);
        end
        mflags = ev[18:16];
        ev = model(4'h5, 16'h8000, 16'h0000, 8'h04, mflags);
        send_op(4'h5, 16'h8000, 16'h0000, 8'h04, ok);
        wait_valid(n, rdy, bsy);
        checks++;
        if (!ok || n != 4 || result !== 16'hF800 || flags !== ev[18:16]) begin
            errors++;
            $display("FAIL sra4: lat=%0d result=%h flags=%b, want lat=4 result=f800 flags=%b",
                     n, result, flags, ev[18:16]);
        end
        mflags = ev[18:16];
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  op;
            logic [15:0] x;
            logic [7:0]  im;
            int          lat;
            op = 4'($urandom_range(4, 6));
            x  = rnd16();
            im = 8'($urandom);
            if (i % 4 == 0) im[3:0] = 4'h0;
            lat = int'(im[3:0]);
            ev  = model(op, x, 16'h0, im, mflags);
            send_op(op, x, 16'h0, im, ok);
            wait_valid(n, rdy, bsy);
            checks++;
            if (!ok || n != lat || result !== ev[15:0] || flags !== ev[18:16]) begin
                errors++;
                $display("FAIL shift_rand op=%h a=%h imm=%h: lat=%0d result=%h flags=%b, want lat=%0d result=%h flags=%b",
                         op, x, im, n, result, flags, lat, ev[15:0], ev[18:16]);
            end
            mflags = ev[18:16];
        end
    endtask

    task automatic test_backpressure();
        logic [18:0] ev1, ev2;
        bit ok;
        tick();
        out_ready = 1'b0;
        ev1 = model(4'h2, 16'h00FF, 16'h0F0F, 8'h00, mflags);
        send_op(4'h2, 16'h00FF, 16'h0F0F, 8'h00, ok);
        mflags = ev1[18:16];
        ev2 = model(4'h0, 16'h1234, 16'h1111, 8'h00, mflags);
        set_op(4'h0, 16'h1234, 16'h1111, 8'h00);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!ok || out_valid !== 1'b1 || result !== 16'h0FF0 || flags !== ev1[18:16] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d: out_valid=%b result=%h flags=%b in_ready=%b, want 1 0ff0 %b 0",
                         i, out_valid, result, flags, in_ready, ev1[18:16]);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h2345 || flags !== ev2[18:16]) begin
            errors++;
            $display("FAIL bp_second_op: out_valid=%b result=%h flags=%b, want 1 2345 %b",
                     out_valid, result, flags, ev2[18:16]);
        end
        mflags = ev2[18:16];
    endtask

    task automatic test_paddsb_red();
        logic [18:0] ev;
        bit ok, r1, b1;
        int n;
        send_op(4'h7, 16'h7878, 16'h1111, 8'h00, ok);
        wait_valid(n, r1, b1);
        checks++;
        if (!ok || n != 0 || result !== 16'h7979 || flags !== mflags) begin
            errors++;
            $display("FAIL paddsb: result=%h flags=%b, want 7979 %b", result, flags, mflags);
        end
        send_op(4'h3, 16'h0101, 16'hFFFF, 8'h00, ok);
        wait_valid(n, r1, b1);
        checks++;
        if (!ok || n != 0 || result !== 16'h0000 || flags !== mflags) begin
            errors++;
            $display("FAIL red: result=%h flags=%b, want 0000 %b", result, flags, mflags);
        end
        for (int i = 0; i < 24; i++) begin
            logic [3:0]  op;
            logic [15:0] x, y;
            logic [7:0]  im;
            case (i % 8)
                0, 1:    op = 4'h7;
                2, 3:    op = 4'h3;
                default: op = 4'(4'h8 + (i % 8) - 4 + ((i / 8) * 4));
            endcase
            x  = rnd16();
            y  = rnd16();
            im = 8'($urandom);
            ev = model(op, x, y, im, mflags);
            send_op(op, x, y, im, ok);
            wait_valid(n, r1, b1);
            checks++;
            if (!ok || n != 0 || result !== ev[15:0] || flags !== ev[18:16]) begin
                errors++;
                $display("FAIL misc_rand op=%h a=%h b=%h imm=%h: result=%h flags=%b, want %h %b",
                         op, x, y, im, result, flags, ev[15:0], ev[18:16]);
            end
            mflags = ev[18:16];
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] ev;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op >= 4'h4 && op <= 4'h6) op = op + 4'h4;
            set_op(op, rnd16(), rnd16(), 8'($urandom));
            ev = model(op, a, b, imm, mflags);
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || result !== ev[15:0] || flags !== ev[18:16] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b i=%0d op=%h: out_valid=%b result=%h flags=%b in_ready=%b, want 1 %h %b 1",
                         i, op, out_valid, result, flags, in_ready, ev[15:0], ev[18:16]);
            end
            mflags = ev[18:16];
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [18:0] ev;
        bit ok, r1, b1, bsy_any;
        int n;
        out_ready = 1'b1;
        send_op(4'h1, 16'h0007, 16'h0007, 8'h00, ok);
        wait_valid(n, r1, b1);
        mflags = 3'b100;
        set_op(4'h0, 16'h0001, 16'h0001, 8'h00);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || flags !== mflags || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: out_valid=%b flags=%b busy=%b, want 0 %b 0", out_valid, flags, busy, mflags);
        end
        send_op(4'h5, 16'h8000, 16'h0000, 8'h0A, ok);
        tick();
        tick();
        set_op(4'h2, 16'h00FF, 16'h0F0F, 8'h00);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (!ok || out_valid !== 1'b0 || busy !== 1'b0 || flags !== mflags || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_shift: out_valid=%b busy=%b flags=%b in_ready=%b, want 0 0 %b 1",
                     out_valid, busy, flags, in_ready, mflags);
        end
        ev = model(4'h2, 16'h00FF, 16'h0F0F, 8'h00, mflags);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0FF0 || flags !== ev[18:16]) begin
            errors++;
            $display("FAIL flush_next_op: out_valid=%b result=%h flags=%b, want 1 0ff0 %b",
                     out_valid, result, flags, ev[18:16]);
        end
        mflags  = ev[18:16];
        bsy_any = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy || out_valid) bsy_any = 1'b1;
        end
        checks++;
        if (bsy_any) begin
            errors++;
            $display("FAIL flush_no_resume: busy/out_valid seen=%b, want 0", bsy_any);
        end
    endtask

    task automatic test_random();
        logic [18:0] ev;
        bit ok, r1, b1;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [15:0] x, y;
            logic [7:0]  im;
            int          lat, stall;
            op  = 4'($urandom_range(0, 15));
            x   = rnd16();
            y   = rnd16();
            im  = 8'($urandom);
            lat = (op >= 4'h4 && op <= 4'h6) ? int'(im[3:0]) : 0;
            ev  = model(op, x, y, im, mflags);
            send_op(op, x, y, im, ok);
            wait_valid(n, r1, b1);
            checks++;
            if (!ok || n != lat || result !== ev[15:0] || flags !== ev[18:16]) begin
                errors++;
                $display("FAIL rand op=%h a=%h b=%h imm=%h: ok=%b lat=%0d result=%h flags=%b, want lat=%0d %h %b",
                         op, x, y, im, ok, n, result, flags, lat, ev[15:0], ev[18:16]);
            end
            mflags = ev[18:16];
            stall  = $urandom_range(0, 3);
            if (stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) tick();
                checks++;
                if (out_valid !== 1'b1 || result !== ev[15:0] || flags !== ev[18:16]) begin
                    errors++;
                    $display("FAIL rand_stall op=%h: out_valid=%b result=%h flags=%b, want 1 %h %b",
                             op, out_valid, result, flags, ev[15:0], ev[18:16]);
                end
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [18:0] ev;
        bit ok, r1, b1;
        int n;
        out_ready = 1'b1;
        send_op(4'h0, 16'h7FF0, 16'h0020, 8'h00, ok);
        wait_valid(n, r1, b1);
        send_op(4'h6, 16'h8001, 16'h0000, 8'h05, ok);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: busy=%b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 16'h0 || flags !== 3'b000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_shift: result=%h flags=%b out_valid=%b busy=%b, want 0000 000 0 0",
                     result, flags, out_valid, busy);
        end
        #2 rst_n = 1'b1;
        mflags = 3'b000;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        ev = model(4'h2, 16'h1234, 16'h1234, 8'h00, mflags);
        send_op(4'h2, 16'h1234, 16'h1234, 8'h00, ok);
        wait_valid(n, r1, b1);
        checks++;
        if (!ok || n != 0 || result !== 16'h0000 || flags !== ev[18:16]) begin
            errors++;
            $display("FAIL rst_after_op: result=%h flags=%b, want 0000 %b", result, flags, ev[18:16]);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_backpressure();
        test_paddsb_red();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
